conv3x3_stream: RTL and testbench

Parametrised successor to the layer convolution unit: a streaming 3x3 convolution engine for raster-ordered pixel frames of configurable size. Internal line buffers and a 3x3 window feed a registered three-stage integer multiply/accumulate pipeline. The output stage applies a shift, an optional absolute value and saturation. Compared with the fixed unit it adds configurable frame geometry, stride, coefficient width, ABS and shift post-processing, a frame-end flag, and a fully synchronous valid with no clock-derived gating.

---
 rtl/conv3x3_stream.sv | 181 ++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 convolution engine with line buffers and 3-stage MAC pipeline
//
// Accepts raster-ordered unsigned pixels, forms a 3x3 window from two line
// buffers plus the incoming pixel, and produces one shifted/saturated result
// per complete (stride-aligned) window, three cycles after the completing pixel.
//
// Ports:
//   Clk        sole clock, rising edge
//   Rst        synchronous active-high reset
//   valid_in   pixel strobe, no backpressure
//   data_in    unsigned pixel, raster order
//   weights    nine signed coefficients, k = 3*r + c at [k*COEF_WIDTH +: COEF_WIDTH]
//   valid_out  one-cycle pulse per output pixel
//   data_out   result, held between pulses
//   last_out   marks the final output of a frame

module conv3x3_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int STRIDE     = 1,
    parameter int SHIFT      = 0,
    parameter int ABS        = 0
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [9*COEF_WIDTH-1:0] weights,
    output logic                    valid_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    last_out
);

    localparam int CW       = $clog2(IMG_WIDTH);
    localparam int RW       = $clog2(IMG_HEIGHT);
    localparam int PW       = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int AW       = DATA_WIDTH + COEF_WIDTH + 5;
    localparam int LAST_ROW = 2 + ((IMG_HEIGHT - 3) / STRIDE) * STRIDE;
    localparam int LAST_COL = 2 + ((IMG_WIDTH - 3) / STRIDE) * STRIDE;

    localparam logic signed [AW-1:0] MAX_VAL = AW'((2 ** DATA_WIDTH) - 1);

    // Coordinates of the next pixel to be accepted.
    logic [CW-1:0] col_in;
    logic [RW-1:0] row_in;

    // lb0 holds the previous row, lb1 the row before that, both indexed by column.
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

    // Window tap k = 3*r + c; column 2 is the newest pixel, row 2 the current row.
    logic [DATA_WIDTH-1:0] win [9];

    logic signed [COEF_WIDTH-1:0] coef [9];
    logic signed [PW-1:0]         prod [9];
    logic signed [AW-1:0]         acc;
    logic signed [AW-1:0]         sum_q;
    logic signed [AW-1:0]         mag;
    logic signed [AW-1:0]         shifted;
    logic [DATA_WIDTH-1:0]        sat_val;

    logic row_ok;
    logic col_ok;
    logic win_complete;
    logic win_last;

    logic win_v, win_l;
    logic prod_v, prod_l;
    logic sum_v, sum_l;

    // Window-complete test uses the coordinate of the pixel being accepted now.
    // With STRIDE 2, (n-2)%2==0 reduces to n being even.
    always_comb begin
        row_ok       = (row_in >= RW'(2)) && ((STRIDE == 1) || !row_in[0]);
        col_ok       = (col_in >= CW'(2)) && ((STRIDE == 1) || !col_in[0]);
        win_complete = row_ok && col_ok;
        win_last     = (row_in == RW'(LAST_ROW)) && (col_in == CW'(LAST_COL));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_in <= '0;
            row_in <= '0;
        end else if (valid_in) begin
            if (col_in == CW'(IMG_WIDTH - 1)) begin
                col_in <= '0;
                if (row_in == RW'(IMG_HEIGHT - 1)) begin
                    row_in <= '0;
                end else begin
                    row_in <= row_in + RW'(1);
                end
            end else begin
                col_in <= col_in + CW'(1);
            end
        end
    end

    // Pure data storage: no reset needed, since every output window only reads
    // rows written earlier in the same frame.
    always_ff @(posedge Clk) begin
        if (valid_in && !Rst) begin
            lb1[col_in] <= lb0[col_in];
            lb0[col_in] <= data_in;
            for (int r = 0; r < 3; r++) begin
                win[3*r]     <= win[3*r+1];
                win[3*r + 1] <= win[3*r+2];
            end
            win[2] <= lb1[col_in];
            win[5] <= lb0[col_in];
            win[8] <= data_in;
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            coef[k] = $signed(weights[k*COEF_WIDTH +: COEF_WIDTH]);
        end
    end

    // S1: products of zero-extended pixels and signed coefficients.
    always_ff @(posedge Clk) begin
        for (int k = 0; k < 9; k++) begin
            prod[k] <= PW'($signed({1'b0, win[k]})) * PW'(coef[k]);
        end
    end

    // S2: nine-way sum; four guard bits make overflow impossible.
    always_comb begin
        acc = '0;
        for (int k = 0; k < 9; k++) begin
            acc = acc + AW'(prod[k]);
        end
    end

    always_ff @(posedge Clk) begin
        sum_q <= acc;
    end

    // S3 input: optional magnitude, floor shift, clamp to the pixel range.
    always_comb begin
        mag     = ((ABS != 0) && sum_q[AW-1]) ? -sum_q : sum_q;
        shifted = mag >>> SHIFT;
        if (shifted[AW-1]) begin
            sat_val = '0;
        end else if (shifted > MAX_VAL) begin
            sat_val = '1;
        end else begin
            sat_val = shifted[DATA_WIDTH-1:0];
        end
    end

    // Valid/last travel alongside the data and never stall.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            win_v     <= 1'b0;
            win_l     <= 1'b0;
            prod_v    <= 1'b0;
            prod_l    <= 1'b0;
            sum_v     <= 1'b0;
            sum_l     <= 1'b0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            data_out  <= '0;
        end else begin
            win_v     <= valid_in && win_complete;
            win_l     <= valid_in && win_complete && win_last;
            prod_v    <= win_v;
            prod_l    <= win_l;
            sum_v     <= prod_v;
            sum_l     <= prod_l;
            valid_out <= sum_v;
            last_out  <= sum_l;
            if (sum_v) begin
                data_out <= sat_val;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - directed scoreboard bench for conv3x3_stream

module tb_conv3x3_stream;

    typedef struct {
        int id;
        int data;
        bit last;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v5, v6;
    logic [7:0]  d5, d6;
    logic [71:0] wb5, wb6s, wb6e;
    logic        vo [5];
    logic        lo [5];
    logic [7:0]  od [5];

    int w5 [9];
    int w6s [9];
    int w6e [9];
    int img5 [5][5];
    int img6 [6][6];
    int y5 = 0, x5 = 0, y6 = 0, x6 = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        wb5  = '0;
        wb6s = '0;
        wb6e = '0;
        for (int k = 0; k < 9; k++) begin
            wb5[k*8 +: 8]  = w5[k][7:0];
            wb6s[k*8 +: 8] = w6s[k][7:0];
            wb6e[k*8 +: 8] = w6e[k][7:0];
        end
    end

    conv3x3_stream #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(1), .SHIFT(0), .ABS(0)) u_a (
        .Clk(clk), .Rst(rst), .valid_in(v5), .data_in(d5), .weights(wb5),
        .valid_out(vo[0]), .data_out(od[0]), .last_out(lo[0]));
    conv3x3_stream #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(1), .SHIFT(4), .ABS(1)) u_b (
        .Clk(clk), .Rst(rst), .valid_in(v5), .data_in(d5), .weights(wb5),
        .valid_out(vo[1]), .data_out(od[1]), .last_out(lo[1]));
    conv3x3_stream #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .STRIDE(1), .SHIFT(0), .ABS(0)) u_c (
        .Clk(clk), .Rst(rst), .valid_in(v6), .data_in(d6), .weights(wb6s),
        .valid_out(vo[2]), .data_out(od[2]), .last_out(lo[2]));
    conv3x3_stream #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .STRIDE(1), .SHIFT(0), .ABS(1)) u_d (
        .Clk(clk), .Rst(rst), .valid_in(v6), .data_in(d6), .weights(wb6s),
        .valid_out(vo[3]), .data_out(od[3]), .last_out(lo[3]));
    conv3x3_stream #(.IMG_WIDTH(6), .IMG_HEIGHT(6), .STRIDE(2), .SHIFT(0), .ABS(0)) u_e (
        .Clk(clk), .Rst(rst), .valid_in(v6), .data_in(d6), .weights(wb6e),
        .valid_out(vo[4]), .data_out(od[4]), .last_out(lo[4]));

    function automatic int post(int s, int absf, int sh);
        int t;
        t = s;
        if (absf != 0 && t < 0) t = -t;
        t = t >>> sh;
        if (t < 0) return 0;
        if (t > 255) return 255;
        return t;
    endfunction

    function automatic int conv5(int y, int x, int w[9]);
        int s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += img5[y-2+r][x-2+c] * w[3*r+c];
        return s;
    endfunction

    function automatic int conv6(int y, int x, int w[9]);
        int s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += img6[y-2+r][x-2+c] * w[3*r+c];
        return s;
    endfunction

    // Output appears at the negedge after the third edge following acceptance.
    task automatic push(input int id, input int data, input bit last);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.last = last;
        e.cyc  = cyc + 4;
        sb.push_back(e);
    endtask

    task automatic step5(input bit v, input int pix);
        int s;
        @(negedge clk);
        v5 = v;
        d5 = pix[7:0];
        if (v) begin
            img5[y5][x5] = pix;
            if (y5 >= 2 && x5 >= 2) begin
                s = conv5(y5, x5, w5);
                push(0, post(s, 0, 0), (y5 == 4 && x5 == 4));
                push(1, post(s, 1, 4), (y5 == 4 && x5 == 4));
            end
            if (x5 == 4) begin
                x5 = 0;
                y5 = (y5 == 4) ? 0 : y5 + 1;
            end else begin
                x5++;
            end
        end
    endtask

    task automatic step6(input int pix);
        int s;
        @(negedge clk);
        v6 = 1'b1;
        d6 = pix[7:0];
        img6[y6][x6] = pix;
        if (y6 >= 2 && x6 >= 2) begin
            s = conv6(y6, x6, w6s);
            push(2, post(s, 0, 0), (y6 == 5 && x6 == 5));
            push(3, post(s, 1, 0), (y6 == 5 && x6 == 5));
            if (y6 % 2 == 0 && x6 % 2 == 0)
                push(4, post(conv6(y6, x6, w6e), 0, 0), (y6 == 4 && x6 == 4));
        end
        if (x6 == 5) begin
            x6 = 0;
            y6 = (y6 == 5) ? 0 : y6 + 1;
        end else begin
            x6++;
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        v5 = 1'b0;
        v6 = 1'b0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d outputs still pending, expected 0", sb.size());
        end
    endtask

    always @(negedge clk) begin : monitor
        int idx;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (vo[i] === 1'b1) begin
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (idx < 0 && sb[j].id == i) idx = j;
                end
                checks++;
                assert (idx >= 0) else begin
                    errors++;
                    $error("FAIL extra_pulse[%0d]: observed valid_out=1 at cycle %0d, expected no output", i, cyc);
                end
                if (idx >= 0) begin
                    e = sb[idx];
                    sb.delete(idx);
                    checks += 3;
                    assert (od[i] === 8'(e.data)) else begin
                        errors++;
                        $error("FAIL data[%0d]: observed %0d, expected %0d", i, od[i], e.data);
                    end
                    assert (lo[i] === e.last) else begin
                        errors++;
                        $error("FAIL last[%0d]: observed %0b, expected %0b", i, lo[i], e.last);
                    end
                    assert (cyc === e.cyc) else begin
                        errors++;
                        $error("FAIL latency[%0d]: observed cycle %0d, expected cycle %0d", i, cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int acc;
        int guard;
        rst = 1'b1;
        v5 = 1'b0;
        v6 = 1'b0;
        d5 = '0;
        d6 = '0;
        for (int k = 0; k < 9; k++) begin
            w5[k]  = 1;
            w6e[k] = 1;
        end
        w6s = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        repeat (3) @(negedge clk);

        // Reset state of every instance
        for (int i = 0; i < 5; i++) begin
            checks += 3;
            assert (vo[i] === 1'b0) else begin
                errors++; $error("FAIL reset_valid[%0d]: observed %b, expected 0", i, vo[i]);
            end
            assert (lo[i] === 1'b0) else begin
                errors++; $error("FAIL reset_last[%0d]: observed %b, expected 0", i, lo[i]);
            end
            assert (od[i] === 8'd0) else begin
                errors++; $error("FAIL reset_data[%0d]: observed %0d, expected 0", i, od[i]);
            end
        end
        rst = 1'b0;

        // Constant frame of 10s with unit weights
        for (int p = 0; p < 25; p++) step5(1'b1, 10);
        drain();

        // Saturation: 255s with unit weights, then with -1 weights
        for (int p = 0; p < 25; p++) step5(1'b1, 255);
        drain();
        for (int k = 0; k < 9; k++) w5[k] = -1;
        for (int p = 0; p < 25; p++) step5(1'b1, 255);
        drain();

        // Sobel on a column ramp, stride-2 box sum on the same frame
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 6; x++) step6(x * 10);
        drain();
        // Sobel and stride-2 on pixel = row*6+col
        for (int y = 0; y < 6; y++)
            for (int x = 0; x < 6; x++) step6(y * 6 + x);
        drain();

        // Two back-to-back frames with random input gaps
        for (int k = 0; k < 9; k++) w5[k] = 1;
        acc = 0;
        guard = 0;
        while (acc < 50 && guard < 2000) begin
            if ($urandom_range(0, 1) == 1) begin
                step5(1'b1, 10);
                acc++;
            end else begin
                step5(1'b0, 0);
            end
            guard++;
        end
        drain();

        // Reset part-way through a frame, then a clean frame
        for (int p = 0; p < 7; p++) step5(1'b1, 10);
        @(negedge clk);
        rst = 1'b1;
        v5 = 1'b1;
        d5 = 8'd200;
        @(negedge clk);
        rst = 1'b0;
        v5 = 1'b0;
        y5 = 0;
        x5 = 0;
        checks += 2;
        assert (vo[0] === 1'b0) else begin
            errors++; $error("FAIL midreset_valid: observed %b, expected 0", vo[0]);
        end
        assert (od[0] === 8'd0) else begin
            errors++; $error("FAIL midreset_data: observed %0d, expected 0", od[0]);
        end
        for (int p = 0; p < 25; p++) step5(1'b1, 10);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
